approxlp_mant_arbiter: RTL and testbench

- Shares one combinational approximate mantissa unit (operands in; mantissa and 2-bit shift out) between NUM_REQ requesters.
- Arbitrates requests round-robin and registers the selected operands in front of the shared unit.
- Registers the unit's result behind it and returns the result on a single tagged response channel with valid/ready backpressure.
- Sits between the per-lane FP multiplier front ends and the shared approximate mantissa datapath.

---
 rtl/approxlp_mant_arbiter.sv | 169 ++++++++++++++++
 tb/tb_approxlp_mant_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/approxlp_mant_arbiter.sv
// -----------------------------------------------------------------------------
// approxlp_mant_arbiter
//
// Shares one combinational approximate mantissa unit between NUM_REQ
// requesters. A round-robin arbiter picks one request per cycle. The chosen
// operands are registered (S1) and drive the shared unit. The unit's result is
// registered (S2) and returned on a single tagged valid/ready response channel.
// The pipeline moves one request per cycle when there is no backpressure.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid/ready     per-requester handshake (at most one ready bit high)
//   req_mant_1/2        packed operands, requester i at [i*WIDTH +: WIDTH]
//   lp_mant_1/2         operands to the shared unit (driven from S1)
//   lp_mant_out/shift   shared unit result (combinational from lp_mant_1/2)
//   resp_*              tagged response channel (driven from S2)
//   stat_grant_cnt      per-requester 16-bit saturating grant counters
//
// Configuration
//   APPROXLP_ARB_STATS_EN  when defined, builds the grant counters. When it is
//                          not defined, stat_grant_cnt is tied to 0.
// -----------------------------------------------------------------------------
module approxlp_mant_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 23,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_mant_1,
  input  logic [NUM_REQ*WIDTH-1:0] req_mant_2,
  output logic [WIDTH-1:0]        lp_mant_1,
  output logic [WIDTH-1:0]        lp_mant_2,
  input  logic [WIDTH-1:0]        lp_mant_out,
  input  logic [1:0]              lp_shift,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [IDW-1:0]          resp_id,
  output logic [WIDTH-1:0]        resp_mant,
  output logic [1:0]              resp_shift,
  output logic [NUM_REQ*16-1:0]   stat_grant_cnt
);

  // Issue stage
  logic             s1_valid;
  logic [IDW-1:0]   s1_id;
  logic [WIDTH-1:0] s1_m1;
  logic [WIDTH-1:0] s1_m2;

  // Result stage
  logic             s2_valid;
  logic [IDW-1:0]   s2_id;
  logic [WIDTH-1:0] s2_mant;
  logic [1:0]       s2_shift;

  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   rr_next;
  logic             found;
  logic             handshake;
  logic             s1_adv;
  logic             s2_adv;

  // S2 can take new data when it is empty or its data is being consumed.
  // S1 can take new data when it is empty or S2 can take its data. These two
  // conditions give full throughput: drain and refill happen in one edge.
  assign s2_adv = !s2_valid || resp_ready;
  assign s1_adv = !s1_valid || s2_adv;

  // Round-robin search that starts at rr_ptr. The candidate index wraps at
  // NUM_REQ, not at 2**IDW, so NUM_REQ does not have to be a power of two.
  always_comb begin : arb_search
    logic [IDW:0] cand;
    // NOTE: every variable in this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(off);
      if (cand >= (IDW+1)'(NUM_REQ)) cand = cand - (IDW+1)'(NUM_REQ);
      if (!found && req_valid[cand[IDW-1:0]]) begin
        found  = 1'b1;
        winner = cand[IDW-1:0];
      end
    end
  end

  always_comb begin : ptr_next
    logic [IDW:0] nxt;
    nxt = {1'b0, winner} + (IDW+1)'(1);
    if (nxt == (IDW+1)'(NUM_REQ)) nxt = '0;
    rr_next = nxt[IDW-1:0];
  end

  // rst_n gates the grant so that nothing is accepted while reset is held.
  assign handshake = found && s1_adv && rst_n;

  always_comb begin
    req_ready = '0;
    if (handshake) req_ready[winner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the data registers are reset as well as the valid bits. This
      // makes lp_* and resp_* read 0 after reset and never show stale data.
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_m1    <= '0;
      s1_m2    <= '0;
      s2_valid <= 1'b0;
      s2_id    <= '0;
      s2_mant  <= '0;
      s2_shift <= '0;
      rr_ptr   <= '0;
    end else begin
      // NOTE: non-blocking assignments here let S2 capture the old S1 value
      // while S1 loads the new request in the same edge.
      if (s1_adv) begin
        if (handshake) begin
          s1_valid <= 1'b1;
          s1_id    <= winner;
          s1_m1    <= req_mant_1[winner*WIDTH +: WIDTH];
          s1_m2    <= req_mant_2[winner*WIDTH +: WIDTH];
          rr_ptr   <= rr_next;
        end else begin
          s1_valid <= 1'b0;
        end
      end
      // The payload loads even when S1 is empty. It is don't-care while
      // s2_valid is low.
      if (s2_adv) begin
        s2_valid <= s1_valid;
        s2_id    <= s1_id;
        s2_mant  <= lp_mant_out;
        s2_shift <= lp_shift;
      end
    end
  end

  assign lp_mant_1  = s1_m1;
  assign lp_mant_2  = s1_m2;
  assign resp_valid = s2_valid;
  assign resp_id    = s2_id;
  assign resp_mant  = s2_mant;
  assign resp_shift = s2_shift;

`ifdef APPROXLP_ARB_STATS_EN
  logic [15:0] grant_cnt [NUM_REQ];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
    end else if (handshake && grant_cnt[winner] != 16'hFFFF) begin
      grant_cnt[winner] <= grant_cnt[winner] + 16'd1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_grant_cnt[g*16 +: 16] = grant_cnt[g];
  end
`else
  assign stat_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_approxlp_mant_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for approxlp_mant_arbiter (NUM_REQ=4, WIDTH=23).
// The shared unit is modelled as lp_mant_out = lp_mant_1 ^ lp_mant_2 with
// lp_shift = 1. The reference model is an ordered queue of in-flight responses
// with a round-robin pointer. Directed scenarios run first, then random
// traffic.
// -----------------------------------------------------------------------------
module tb_approxlp_mant_arbiter;
  localparam int N = 4;
  localparam int W = 23;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_mant_1;
  logic [N*W-1:0]   req_mant_2;
  logic [W-1:0]     lp_mant_1;
  logic [W-1:0]     lp_mant_2;
  logic [W-1:0]     lp_mant_out;
  logic [1:0]       lp_shift;
  logic             resp_valid;
  logic             resp_ready;
  logic [1:0]       resp_id;
  logic [W-1:0]     resp_mant;
  logic [1:0]       resp_shift;
  logic [N*16-1:0]  stat_grant_cnt;

  always #5 clk = ~clk;

  assign lp_mant_out = lp_mant_1 ^ lp_mant_2;
  assign lp_shift    = 2'b01;

  approxlp_mant_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_mant_1     (req_mant_1),
    .req_mant_2     (req_mant_2),
    .lp_mant_1      (lp_mant_1),
    .lp_mant_2      (lp_mant_2),
    .lp_mant_out    (lp_mant_out),
    .lp_shift       (lp_shift),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_id        (resp_id),
    .resp_mant      (resp_mant),
    .resp_shift     (resp_shift),
    .stat_grant_cnt (stat_grant_cnt)
  );

  // Reference model state
  typedef struct {
    int         id;
    logic [W-1:0] mant;
    bit         vis;   // visible on the response port
  } item_t;

  item_t        q[$];
  int           ptr;
  int           grants [N];
  logic [W-1:0] m1 [N];
  logic [W-1:0] m2 [N];
  int           dut_hs;
  int           n_checks;
  int           n_pass;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      m1[i] = W'($urandom);
      m2[i] = W'($urandom);
    end
  endtask

  // Called just after a falling edge. Drives the inputs, checks the outputs
  // against the model, crosses one rising edge, updates the model, and
  // returns on the next falling edge.
  task automatic step(input logic [N-1:0] v, input logic rr);
    int           win;
    bit           acc;
    logic [N-1:0] exp_rdy;
    logic         exp_valid;
    for (int i = 0; i < N; i++) begin
      req_mant_1[i*W +: W] = m1[i];
      req_mant_2[i*W +: W] = m2[i];
    end
    req_valid  = v;
    resp_ready = rr;
    #1;
    win = -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (ptr + k) % N;
      if (win < 0 && v[i]) win = i;
    end
    acc = (q.size() < 2) || (q[0].vis && rr);
    exp_rdy = '0;
    if (win >= 0 && acc) exp_rdy[win] = 1'b1;
    check("req_ready", req_ready, exp_rdy);
    exp_valid = (q.size() > 0) && q[0].vis;
    check("resp_valid", resp_valid, exp_valid);
    if (exp_valid) begin
      check("resp_id", resp_id, q[0].id);
      check("resp_mant", resp_mant, q[0].mant);
      check("resp_shift", resp_shift, 2'b01);
    end
    if (|(req_valid & req_ready)) dut_hs++;
    @(posedge clk);
    if (q.size() > 0 && q[0].vis && rr) void'(q.pop_front());
    if (q.size() > 0 && !q[0].vis) q[0].vis = 1'b1;
    if (win >= 0 && acc) begin
      q.push_back('{id: win, mant: m1[win] ^ m2[win], vis: 1'b0});
      ptr = (win + 1) % N;
      grants[win]++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '1;
    #1;
    check("rst_req_ready", req_ready, 0);
    @(posedge clk);
    #1;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_id", resp_id, 0);
    check("rst_resp_mant", resp_mant, 0);
    check("rst_resp_shift", resp_shift, 0);
    check("rst_lp_mant_1", lp_mant_1, 0);
    check("rst_lp_mant_2", lp_mant_2, 0);
    check("rst_req_ready_hold", req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    ptr = 0;
    for (int i = 0; i < N; i++) grants[i] = 0;
  endtask

  task automatic check_stats(input string tag);
    for (int i = 0; i < N; i++) begin
`ifdef APPROXLP_ARB_STATS_EN
      check(tag, stat_grant_cnt[i*16 +: 16], (grants[i] > 65535) ? 65535 : grants[i]);
`else
      check(tag, stat_grant_cnt[i*16 +: 16], 0);
`endif
    end
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    dut_hs     = 0;
    rst_n      = 1'b0;
    req_valid  = '0;
    resp_ready = 1'b0;
    req_mant_1 = '0;
    req_mant_2 = '0;
    rand_ops();
    @(negedge clk);
    do_reset();

    // Single request from requester 2
    m1[2] = 23'h400000;
    m2[2] = 23'h000001;
    step(4'b0100, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);

    // Round-robin with all requesters valid
    rand_ops();
    for (int c = 0; c < 8; c++) step(4'b1111, 1'b1);
    for (int c = 0; c < 3; c++) step(4'b0000, 1'b1);

    // Backpressure: two accepts, then stall, then drain in order
    rand_ops();
    dut_hs = 0;
    for (int c = 0; c < 12; c++) step(4'b0011, 1'b0);
    check("bp_handshakes", dut_hs, 2);
    for (int c = 0; c < 3; c++) step(4'b0000, 1'b1);

    // Pointer wrap: requester 3, then requester 0
    rand_ops();
    step(4'b1000, 1'b1);
    step(4'b0001, 1'b1);
    for (int c = 0; c < 3; c++) step(4'b0000, 1'b1);

    // Reset with both stages full
    rand_ops();
    for (int c = 0; c < 3; c++) step(4'b0011, 1'b0);
    do_reset();
    rand_ops();
    step(4'b1010, 1'b1);
    for (int c = 0; c < 3; c++) step(4'b0000, 1'b1);

    // Grant counters: requester 1 granted five times
    do_reset();
    rand_ops();
    for (int c = 0; c < 5; c++) step(4'b0010, 1'b1);
    for (int c = 0; c < 3; c++) step(4'b0000, 1'b1);
    check_stats("stat_cnt");

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      rand_ops();
      step(N'($urandom), ($urandom_range(0, 3) != 0));
    end
    for (int c = 0; c < 4; c++) step(4'b0000, 1'b1);
    check_stats("stat_cnt_rand");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
